// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline, including the HI/LO mult/div busy countdown.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4  // legal range 2..31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_UsesHiLo,
  input  logic        ID_IsMulDiv,
  input  logic        EX_RegWrite,
  input  logic        EX_MemToReg,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_Redirect,
  input  logic        EX_MulDivStart,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Stall,
  output logic        MD_Busy,
  output logic [31:0] Perf_StallCnt,
  output logic [31:0] Perf_FlushCnt
);

  typedef enum logic {IDLE, MD_WAIT} md_state_t;

  localparam logic [4:0] MD_LOAD = 5'(MULDIV_CYCLES - 1);

  logic [4:0] md_cnt_reg;
  logic [4:0] md_cnt_next;
  md_state_t  md_state;
  logic       lu;
  logic       hl;
  logic       st;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_reg <= 5'd0;
    end else begin
      md_cnt_reg <= md_cnt_next;
    end
  end

  // A new mult/div always reloads, even over an unfinished one; otherwise count down to 0.
  always_comb begin
    md_state    = (md_cnt_reg != 5'd0) ? MD_WAIT : IDLE;
    md_cnt_next = md_cnt_reg;
    if (EX_MulDivStart) begin
      md_cnt_next = MD_LOAD;
    end else begin
      case (md_state)
        MD_WAIT: md_cnt_next = md_cnt_reg - 5'd1;
        default: md_cnt_next = 5'd0;
      endcase
    end
  end

  always_comb begin
    lu = EX_MemToReg & EX_RegWrite & (EX_WriteReg != 5'd0) &
         ((ID_UsesRs & (ID_rs == EX_WriteReg)) | (ID_UsesRt & (ID_rt == EX_WriteReg)));
    // md_cnt==1 means HI/LO is written at the end of this cycle, so the reader may proceed.
    hl = (ID_UsesHiLo | ID_IsMulDiv) & (EX_MulDivStart | (md_cnt_reg >= 5'd2));
    st = lu | hl;
  end

  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Stall = 1'b0;
    if (!reset) begin
      if (EX_Redirect) begin
        // The ID instruction is wrong-path, so its own stall request is moot.
        IF_ID_Flush = 1'b1;
        ID_EX_Stall = 1'b1;
      end else if (st) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Stall = 1'b1;
      end
    end
  end

  assign MD_Busy = ~reset & (md_state == MD_WAIT);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (EX_Redirect) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end else if (st) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign Perf_StallCnt = stall_cnt_reg;
  assign Perf_FlushCnt = flush_cnt_reg;
`else
  assign Perf_StallCnt = 32'd0;
  assign Perf_FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, HI/LO wait, redirect priority, back-to-back mult/div, reset, counters.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt;
  logic        ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_IsMulDiv;
  logic        EX_RegWrite, EX_MemToReg;
  logic [4:0]  EX_WriteReg;
  logic        EX_Redirect, EX_MulDivStart;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Stall, MD_Busy;
  logic [31:0] Perf_StallCnt, Perf_FlushCnt;
  logic [3:0]  ctrl;

  int n_checks = 0;
  int n_errors = 0;
  int exp_st = 0;
  int exp_fl = 0;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Stall}
  localparam logic [3:0] IDL = 4'b1100;
  localparam logic [3:0] STL = 4'b0001;
  localparam logic [3:0] FLS = 4'b1111;

  hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_UsesHiLo(ID_UsesHiLo), .ID_IsMulDiv(ID_IsMulDiv),
    .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_WriteReg(EX_WriteReg), .EX_Redirect(EX_Redirect),
    .EX_MulDivStart(EX_MulDivStart),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Stall(ID_EX_Stall),
    .MD_Busy(MD_Busy),
    .Perf_StallCnt(Perf_StallCnt), .Perf_FlushCnt(Perf_FlushCnt)
  );

  assign ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [3:0] e);
    check(tag, {28'd0, ctrl}, {28'd0, e});
    if (e == STL) exp_st++;
    else if (e == FLS) exp_fl++;
    $display("cycle %-12s ctrl=%b busy=%b", tag, ctrl, MD_Busy);
  endtask

  task automatic clr();
    reset = 1'b0;
    ID_rs = 5'd0; ID_rt = 5'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_UsesHiLo = 1'b0; ID_IsMulDiv = 1'b0;
    EX_RegWrite = 1'b0; EX_MemToReg = 1'b0; EX_WriteReg = 5'd0;
    EX_Redirect = 1'b0; EX_MulDivStart = 1'b0;
  endtask

  // Advance one edge, clear inputs, caller then drives and waits for the negedge to sample.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    EX_MemToReg = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = rd;
  endtask

  task automatic check_perf(input string tag);
    logic [31:0] es, ef;
    es = 32'(exp_st);
    ef = 32'(exp_fl);
`ifndef HAZARD_PERF_EN
    es = 32'd0;
    ef = 32'd0;
`endif
    check({tag, "_stall"}, Perf_StallCnt, es);
    check({tag, "_flush"}, Perf_FlushCnt, ef);
  endtask

  initial begin
    clr();
    // Reset forces idle outputs even with redirect/start requests present.
    reset = 1'b1; EX_Redirect = 1'b1; ID_UsesHiLo = 1'b1; EX_MulDivStart = 1'b1;
    @(negedge clk);
    ctl("rst_ctrl", IDL);
    check("rst_busy", {31'd0, MD_Busy}, 32'd0);
    next_cycle(); reset = 1'b1; EX_MulDivStart = 1'b1;
    @(negedge clk);
    ctl("rst_ctrl2", IDL);
    next_cycle();
    @(negedge clk);
    ctl("post_rst", IDL);
    check("post_rst_busy", {31'd0, MD_Busy}, 32'd0);
    check_perf("post_rst");

    // Load-use on rs: one stall, then the load is in MEM.
    next_cycle(); load_in_ex(5'd5); ID_UsesRs = 1'b1; ID_rs = 5'd5;
    @(negedge clk); ctl("lu_rs", STL);
    next_cycle(); ID_UsesRs = 1'b1; ID_rs = 5'd5;
    @(negedge clk); ctl("lu_after", IDL);
    next_cycle(); load_in_ex(5'd7); ID_UsesRt = 1'b1; ID_rt = 5'd7;
    @(negedge clk); ctl("lu_rt", STL);
    next_cycle(); load_in_ex(5'd7); ID_rs = 5'd7;
    @(negedge clk); ctl("lu_nouse", IDL);
    next_cycle(); load_in_ex(5'd0); ID_UsesRs = 1'b1; ID_rs = 5'd0;
    @(negedge clk); ctl("lu_r0", IDL);
    next_cycle(); EX_MemToReg = 1'b0; EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
    ID_UsesRs = 1'b1; ID_rs = 5'd9;
    @(negedge clk); ctl("alu_dep", IDL);

    // MFHI behind mult: stalls in t..t+2, busy t+1..t+3.
    next_cycle(); EX_MulDivStart = 1'b1; ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("md_t0", STL);
    check("md_t0_busy", {31'd0, MD_Busy}, 32'd0);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("md_t1", STL);
    check("md_t1_busy", {31'd0, MD_Busy}, 32'd1);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("md_t2", STL);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("md_t3", IDL);
    check("md_t3_busy", {31'd0, MD_Busy}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("md_t4_busy", {31'd0, MD_Busy}, 32'd0);

    // Redirect beats load-use and HI/LO stall, and leaves md_cnt running.
    next_cycle(); EX_MulDivStart = 1'b1;
    @(negedge clk); ctl("rd_t0", IDL);
    next_cycle(); EX_Redirect = 1'b1; ID_UsesHiLo = 1'b1;
    load_in_ex(5'd3); ID_UsesRs = 1'b1; ID_rs = 5'd3;
    @(negedge clk); ctl("rd_flush", FLS);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("rd_t2", STL);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("rd_t3", IDL);
    check("rd_t3_busy", {31'd0, MD_Busy}, 32'd1);

    // Back-to-back mult: 3 stalls, then the second start reloads to 3.
    next_cycle(); EX_MulDivStart = 1'b1; ID_IsMulDiv = 1'b1;
    @(negedge clk); ctl("b2b_t0", STL);
    next_cycle(); ID_IsMulDiv = 1'b1;
    @(negedge clk); ctl("b2b_t1", STL);
    next_cycle(); ID_IsMulDiv = 1'b1;
    @(negedge clk); ctl("b2b_t2", STL);
    next_cycle(); ID_IsMulDiv = 1'b1;
    @(negedge clk); ctl("b2b_t3", IDL);
    next_cycle(); EX_MulDivStart = 1'b1;
    @(negedge clk); ctl("b2b_t4", IDL);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("b2b_t5", STL);
    check("b2b_t5_busy", {31'd0, MD_Busy}, 32'd1);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("b2b_t6", STL);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("b2b_t7", IDL);
    next_cycle();
    @(negedge clk);
    check_perf("perf");

    // Reset during MD_WAIT discards the pending result.
    next_cycle(); EX_MulDivStart = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk); check("mr_t1_busy", {31'd0, MD_Busy}, 32'd1);
    next_cycle(); reset = 1'b1; ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("mr_rst", IDL);
    check("mr_rst_busy", {31'd0, MD_Busy}, 32'd0);
    next_cycle(); ID_UsesHiLo = 1'b1;
    @(negedge clk); ctl("mr_t3", IDL);
    check("mr_t3_busy", {31'd0, MD_Busy}, 32'd0);
    exp_st = 0;
    exp_fl = 0;
    check_perf("mr_perf");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
